millennium_rtc_core: RTL and testbench

- Parametrised BCD real-time calendar core: seconds, minutes, hours, day, month and 4-digit year.
- Advances on a 1 Hz tick enable in the system clock domain. It does not run on a derived clock.
- Provides Gregorian leap-year handling, a configurable year window, per-field set mode with wrap, day clamping and rollover pulses.
- Sits between the 1 Hz tick generator/control FSM and the 7-segment display scanner, replacing the fixed-range counter.

---
 rtl/millennium_rtc_core_if.sv | 29 ++
 rtl/millennium_rtc_core.sv | 227 ++++++++++++++++++++++
 tb/tb_millennium_rtc_core.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/millennium_rtc_core_if.sv
// Control and display bus of the calendar core: edit/tick inputs in, BCD fields and rollover pulses out.
interface millennium_rtc_core_if;
  logic        tick_1hz;
  logic        en;
  logic [2:0]  select_item;
  logic        up;
  logic        down;
  logic [7:0]  bcd_ss;
  logic [7:0]  bcd_mm;
  logic [7:0]  bcd_hh;
  logic [7:0]  bcd_dd;
  logic [7:0]  bcd_mo;
  logic [15:0] bcd_yyyy;
  logic        min_pulse;
  logic        day_pulse;
  logic        year_wrap;

  modport master (
    output tick_1hz, en, select_item, up, down,
    input  bcd_ss, bcd_mm, bcd_hh, bcd_dd, bcd_mo, bcd_yyyy,
    input  min_pulse, day_pulse, year_wrap
  );

  modport slave (
    input  tick_1hz, en, select_item, up, down,
    output bcd_ss, bcd_mm, bcd_hh, bcd_dd, bcd_mo, bcd_yyyy,
    output min_pulse, day_pulse, year_wrap
  );
endinterface

// File: rtl/millennium_rtc_core.sv
// BCD calendar core: time fields kept in binary with registered BCD copies, year kept natively in BCD.
// Advances on a 1 Hz enable; set mode edits one field at a time with wrap and day clamping.
module millennium_rtc_core #(
  parameter int YEAR_MIN   = 2000,
  parameter int YEAR_MAX   = 2999,
  parameter int RESET_YEAR = 2000
) (
  input  logic                  clk,
  input  logic                  rst,
  millennium_rtc_core_if.slave  bus
);

  typedef enum logic [2:0] {
    SEL_SS   = 3'd0,
    SEL_MM   = 3'd1,
    SEL_HH   = 3'd2,
    SEL_DD   = 3'd3,
    SEL_MO   = 3'd4,
    SEL_YYYY = 3'd5
  } sel_e;

  function automatic logic [15:0] bin_to_bcd16(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] bin_to_bcd8(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  function automatic logic [15:0] bcd16_inc(input logic [15:0] y);
    logic [15:0] r;
    logic        carry;
    r     = y;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd16_dec(input logic [15:0] y);
    logic [15:0] r;
    logic        borrow;
    r      = y;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (r[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Century years (low pair 00) are leap only when the high pair is a multiple of 4.
  function automatic logic is_leap_bcd(input logic [15:0] y);
    logic [6:0] lo;
    logic [6:0] hi;
    lo = {3'd0, y[7:4]}   * 7'd10 + {3'd0, y[3:0]};
    hi = {3'd0, y[15:12]} * 7'd10 + {3'd0, y[11:8]};
    if (lo == 7'd0) return (hi % 7'd4) == 7'd0;
    return (lo % 7'd4) == 7'd0;
  endfunction

  function automatic logic [4:0] days_in_month(input logic [3:0] mo, input logic [15:0] y);
    case (mo)
      4'd2:                    return is_leap_bcd(y) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
      default:                 return 5'd31;
    endcase
  endfunction

  localparam logic [15:0] YMIN_BCD = bin_to_bcd16(YEAR_MIN);
  localparam logic [15:0] YMAX_BCD = bin_to_bcd16(YEAR_MAX);
  localparam logic [15:0] YRST_BCD = bin_to_bcd16(RESET_YEAR);

  if (YEAR_MIN < 0 || YEAR_MAX > 9999 || YEAR_MIN > YEAR_MAX ||
      RESET_YEAR < YEAR_MIN || RESET_YEAR > YEAR_MAX) begin : g_bad_params
    $error("millennium_rtc_core: invalid YEAR_MIN/YEAR_MAX/RESET_YEAR");
  end

  logic [5:0]  r_ss, r_mm;
  logic [4:0]  r_hh, r_dd;
  logic [3:0]  r_mo;
  logic [15:0] r_yyyy;
  logic [7:0]  r_bcd_ss, r_bcd_mm, r_bcd_hh, r_bcd_dd, r_bcd_mo;
  logic        r_min_pulse, r_day_pulse, r_year_wrap;

  logic [5:0]  w_ss, w_mm;
  logic [4:0]  w_hh, w_dd;
  logic [3:0]  w_mo;
  logic [15:0] w_yyyy;
  logic        w_min_pulse, w_day_pulse, w_year_wrap;
  logic        w_step_up, w_step_dn;
  logic [4:0]  w_dim_cur, w_dim_new;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_ss        = r_ss;
    w_mm        = r_mm;
    w_hh        = r_hh;
    w_dd        = r_dd;
    w_mo        = r_mo;
    w_yyyy      = r_yyyy;
    w_min_pulse = 1'b0;
    w_day_pulse = 1'b0;
    w_year_wrap = 1'b0;
    w_step_up   = bus.up & ~bus.down;
    w_step_dn   = bus.down & ~bus.up;
    w_dim_cur   = days_in_month(r_mo, r_yyyy);

    if (bus.en) begin
      if (bus.tick_1hz) begin
        if (r_ss == 6'd59) begin
          w_ss        = 6'd0;
          w_min_pulse = 1'b1;
          if (r_mm == 6'd59) begin
            w_mm = 6'd0;
            if (r_hh == 5'd23) begin
              w_hh        = 5'd0;
              w_day_pulse = 1'b1;
              if (r_dd == w_dim_cur) begin
                w_dd = 5'd1;
                if (r_mo == 4'd12) begin
                  w_mo = 4'd1;
                  if (r_yyyy == YMAX_BCD) begin
                    w_yyyy      = YMIN_BCD;
                    w_year_wrap = 1'b1;
                  end else begin
                    w_yyyy = bcd16_inc(r_yyyy);
                  end
                end else begin
                  w_mo = r_mo + 4'd1;
                end
              end else begin
                w_dd = r_dd + 5'd1;
              end
            end else begin
              w_hh = r_hh + 5'd1;
            end
          end else begin
            w_mm = r_mm + 6'd1;
          end
        end else begin
          w_ss = r_ss + 6'd1;
        end
      end
    end else if (w_step_up || w_step_dn) begin
      case (bus.select_item)
        SEL_SS: w_ss = w_step_up ? ((r_ss == 6'd59) ? 6'd0  : r_ss + 6'd1)
                                 : ((r_ss == 6'd0)  ? 6'd59 : r_ss - 6'd1);
        SEL_MM: w_mm = w_step_up ? ((r_mm == 6'd59) ? 6'd0  : r_mm + 6'd1)
                                 : ((r_mm == 6'd0)  ? 6'd59 : r_mm - 6'd1);
        SEL_HH: w_hh = w_step_up ? ((r_hh == 5'd23) ? 5'd0  : r_hh + 5'd1)
                                 : ((r_hh == 5'd0)  ? 5'd23 : r_hh - 5'd1);
        SEL_DD: w_dd = w_step_up ? ((r_dd == w_dim_cur) ? 5'd1 : r_dd + 5'd1)
                                 : ((r_dd == 5'd1) ? w_dim_cur : r_dd - 5'd1);
        SEL_MO: w_mo = w_step_up ? ((r_mo == 4'd12) ? 4'd1  : r_mo + 4'd1)
                                 : ((r_mo == 4'd1)  ? 4'd12 : r_mo - 4'd1);
        SEL_YYYY: w_yyyy = w_step_up ? ((r_yyyy == YMAX_BCD) ? YMIN_BCD : bcd16_inc(r_yyyy))
                                     : ((r_yyyy == YMIN_BCD) ? YMAX_BCD : bcd16_dec(r_yyyy));
        default: ;
      endcase
    end

    // A month or year edit can shorten the month under the current day.
    w_dim_new = days_in_month(w_mo, w_yyyy);
    if (w_dd > w_dim_new) w_dd = w_dim_new;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_ss        <= 6'd0;
      r_mm        <= 6'd0;
      r_hh        <= 5'd0;
      r_dd        <= 5'd1;
      r_mo        <= 4'd1;
      r_yyyy      <= YRST_BCD;
      r_bcd_ss    <= 8'h00;
      r_bcd_mm    <= 8'h00;
      r_bcd_hh    <= 8'h00;
      r_bcd_dd    <= 8'h01;
      r_bcd_mo    <= 8'h01;
      r_min_pulse <= 1'b0;
      r_day_pulse <= 1'b0;
      r_year_wrap <= 1'b0;
    end else begin
      r_ss        <= w_ss;
      r_mm        <= w_mm;
      r_hh        <= w_hh;
      r_dd        <= w_dd;
      r_mo        <= w_mo;
      r_yyyy      <= w_yyyy;
      r_bcd_ss    <= bin_to_bcd8({1'b0, w_ss});
      r_bcd_mm    <= bin_to_bcd8({1'b0, w_mm});
      r_bcd_hh    <= bin_to_bcd8({2'b0, w_hh});
      r_bcd_dd    <= bin_to_bcd8({2'b0, w_dd});
      r_bcd_mo    <= bin_to_bcd8({3'b0, w_mo});
      r_min_pulse <= w_min_pulse;
      r_day_pulse <= w_day_pulse;
      r_year_wrap <= w_year_wrap;
    end
  end

  assign bus.bcd_ss    = r_bcd_ss;
  assign bus.bcd_mm    = r_bcd_mm;
  assign bus.bcd_hh    = r_bcd_hh;
  assign bus.bcd_dd    = r_bcd_dd;
  assign bus.bcd_mo    = r_bcd_mo;
  assign bus.bcd_yyyy  = r_yyyy;
  assign bus.min_pulse = r_min_pulse;
  assign bus.day_pulse = r_day_pulse;
  assign bus.year_wrap = r_year_wrap;

endmodule

// File: tb/tb_millennium_rtc_core.sv
// Bench for millennium_rtc_core: vector table, directed calendar corners, then random traffic
// compared against a calendar model built from seconds-of-day arithmetic.
module tb_millennium_rtc_core;
  localparam int YEAR_MIN   = 2000;
  localparam int YEAR_MAX   = 2999;
  localparam int RESET_YEAR = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  millennium_rtc_core_if bus ();

  millennium_rtc_core #(
    .YEAR_MIN   (YEAR_MIN),
    .YEAR_MAX   (YEAR_MAX),
    .RESET_YEAR (RESET_YEAR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  int m_ss, m_mm, m_hh, m_dd, m_mo, m_yr;
  bit m_min, m_day, m_wrap;

  typedef struct {
    bit       rst, tick, en;
    bit [2:0] sel;
    bit       up, dn;
    int       ss, mm, hh, dd, mo, yr;
    bit       mp, dp, yw;
  } vec_t;

  vec_t vecs[$];

  function automatic bit is_leap(int y);
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
  endfunction

  function automatic int dim(int m, int y);
    case (m)
      2:             return is_leap(y) ? 29 : 28;
      4, 6, 9, 11:   return 30;
      default:       return 31;
    endcase
  endfunction

  function automatic int wrap_add(int v, int lo, int hi, int d);
    int span;
    span = hi - lo + 1;
    return lo + ((v - lo + d + span) % span);
  endfunction

  function automatic logic [15:0] bcd(int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int model_field(bit [2:0] s);
    case (s)
      3'd0:    return m_ss;
      3'd1:    return m_mm;
      3'd2:    return m_hh;
      3'd3:    return m_dd;
      3'd4:    return m_mo;
      default: return m_yr;
    endcase
  endfunction

  task automatic model_step(bit r, bit t, bit e, bit [2:0] s, bit u, bit d);
    int sod;
    int delta;
    m_min  = 0;
    m_day  = 0;
    m_wrap = 0;
    if (r) begin
      m_ss = 0; m_mm = 0; m_hh = 0; m_dd = 1; m_mo = 1; m_yr = RESET_YEAR;
    end else if (e) begin
      if (t) begin
        sod = m_hh * 3600 + m_mm * 60 + m_ss + 1;
        m_min = (sod % 60 == 0);
        if (sod == 86400) begin
          sod   = 0;
          m_day = 1;
          m_dd++;
          if (m_dd > dim(m_mo, m_yr)) begin
            m_dd = 1;
            m_mo++;
            if (m_mo > 12) begin
              m_mo = 1;
              m_yr++;
              if (m_yr > YEAR_MAX) begin
                m_yr   = YEAR_MIN;
                m_wrap = 1;
              end
            end
          end
        end
        m_hh = sod / 3600;
        m_mm = (sod / 60) % 60;
        m_ss = sod % 60;
      end
    end else if (u != d) begin
      delta = u ? 1 : -1;
      case (s)
        3'd0: m_ss = wrap_add(m_ss, 0, 59, delta);
        3'd1: m_mm = wrap_add(m_mm, 0, 59, delta);
        3'd2: m_hh = wrap_add(m_hh, 0, 23, delta);
        3'd3: m_dd = wrap_add(m_dd, 1, dim(m_mo, m_yr), delta);
        3'd4: m_mo = wrap_add(m_mo, 1, 12, delta);
        3'd5: m_yr = wrap_add(m_yr, YEAR_MIN, YEAR_MAX, delta);
        default: ;
      endcase
      if (m_dd > dim(m_mo, m_yr)) m_dd = dim(m_mo, m_yr);
    end
  endtask

  task automatic step(bit r, bit t, bit e, bit [2:0] s, bit u, bit d);
    rst             = r;
    bus.tick_1hz    = t;
    bus.en          = e;
    bus.select_item = s;
    bus.up          = u;
    bus.down        = d;
    model_step(r, t, e, s, u, d);
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(string tag, int ss, int mm, int hh, int dd, int mo, int yr,
                             bit mp, bit dp, bit yw);
    check({tag, " ss"},   32'(bus.bcd_ss),    32'(bcd(ss)));
    check({tag, " mm"},   32'(bus.bcd_mm),    32'(bcd(mm)));
    check({tag, " hh"},   32'(bus.bcd_hh),    32'(bcd(hh)));
    check({tag, " dd"},   32'(bus.bcd_dd),    32'(bcd(dd)));
    check({tag, " mo"},   32'(bus.bcd_mo),    32'(bcd(mo)));
    check({tag, " yyyy"}, 32'(bus.bcd_yyyy),  32'(bcd(yr)));
    check({tag, " min_pulse"}, 32'(bus.min_pulse), 32'(mp));
    check({tag, " day_pulse"}, 32'(bus.day_pulse), 32'(dp));
    check({tag, " year_wrap"}, 32'(bus.year_wrap), 32'(yw));
  endtask

  task automatic set_field(bit [2:0] s, int target);
    int cur;
    for (int n = 0; n < 2000; n++) begin
      cur = model_field(s);
      if (cur == target) break;
      step(0, 0, 0, s, target > cur, target < cur);
    end
  endtask

  // Reset, then walk each field to the target in set mode (year and month first so the day fits).
  task automatic goto_date(int yr, int mo, int dd, int hh, int mm, int ss);
    step(1, 0, 0, 0, 0, 0);
    set_field(5, yr);
    set_field(4, mo);
    set_field(3, dd);
    set_field(2, hh);
    set_field(1, mm);
    set_field(0, ss);
    check_state("goto", ss, mm, hh, dd, mo, yr, 0, 0, 0);
  endtask

  initial begin
    bit r, t, e, u, d;
    bit [2:0] s;

    bus.tick_1hz = 0; bus.en = 0; bus.select_item = 0; bus.up = 0; bus.down = 0;

    //                  rst tk en sel up dn  ss mm hh dd mo yr    mp dp yw
    vecs.push_back(vec_t'{1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 2000, 0, 0, 0});
    vecs.push_back(vec_t'{1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 2000, 0, 0, 0});
    vecs.push_back(vec_t'{0, 1, 1, 0, 0, 0,  1, 0, 0, 1, 1, 2000, 0, 0, 0});
    vecs.push_back(vec_t'{0, 1, 1, 0, 0, 0,  2, 0, 0, 1, 1, 2000, 0, 0, 0});
    vecs.push_back(vec_t'{0, 1, 1, 0, 0, 0,  3, 0, 0, 1, 1, 2000, 0, 0, 0});
    vecs.push_back(vec_t'{0, 1, 0, 0, 0, 0,  3, 0, 0, 1, 1, 2000, 0, 0, 0});
    vecs.push_back(vec_t'{1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 2000, 0, 0, 0});
    vecs.push_back(vec_t'{0, 0, 0, 0, 0, 1, 59, 0, 0, 1, 1, 2000, 0, 0, 0});
    vecs.push_back(vec_t'{0, 0, 0, 1, 0, 1, 59,59, 0, 1, 1, 2000, 0, 0, 0});
    vecs.push_back(vec_t'{0, 0, 0, 2, 0, 1, 59,59,23, 1, 1, 2000, 0, 0, 0});
    vecs.push_back(vec_t'{0, 0, 0, 3, 0, 1, 59,59,23,31, 1, 2000, 0, 0, 0});
    vecs.push_back(vec_t'{0, 0, 0, 4, 0, 1, 59,59,23,31,12, 2000, 0, 0, 0});
    vecs.push_back(vec_t'{0, 0, 0, 5, 0, 1, 59,59,23,31,12, 2999, 0, 0, 0});
    vecs.push_back(vec_t'{0, 1, 1, 0, 0, 0,  0, 0, 0, 1, 1, 2000, 1, 1, 1});
    vecs.push_back(vec_t'{0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 1, 2000, 0, 0, 0});
    vecs.push_back(vec_t'{0, 0, 0, 1, 1, 1,  0, 0, 0, 1, 1, 2000, 0, 0, 0});
    vecs.push_back(vec_t'{0, 0, 0, 7, 1, 0,  0, 0, 0, 1, 1, 2000, 0, 0, 0});
    vecs.push_back(vec_t'{0, 0, 1, 0, 1, 0,  0, 0, 0, 1, 1, 2000, 0, 0, 0});
    vecs.push_back(vec_t'{0, 0, 0, 3, 0, 1,  0, 0, 0,31, 1, 2000, 0, 0, 0});
    vecs.push_back(vec_t'{0, 0, 0, 4, 1, 0,  0, 0, 0,29, 2, 2000, 0, 0, 0});

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].tick, vecs[i].en, vecs[i].sel, vecs[i].up, vecs[i].dn);
      check_state($sformatf("vec%0d", i), vecs[i].ss, vecs[i].mm, vecs[i].hh,
                  vecs[i].dd, vecs[i].mo, vecs[i].yr, vecs[i].mp, vecs[i].dp, vecs[i].yw);
    end

    goto_date(2024, 2, 28, 23, 59, 59);
    step(0, 1, 1, 0, 0, 0);
    check_state("leap2024", 0, 0, 0, 29, 2, 2024, 1, 1, 0);

    goto_date(2100, 2, 28, 23, 59, 59);
    step(0, 1, 1, 0, 0, 0);
    check_state("noleap2100", 0, 0, 0, 1, 3, 2100, 1, 1, 0);

    goto_date(2000, 2, 28, 23, 59, 59);
    step(0, 1, 1, 0, 0, 0);
    check_state("leap2000", 0, 0, 0, 29, 2, 2000, 1, 1, 0);

    goto_date(2023, 1, 31, 0, 0, 0);
    step(0, 0, 0, 4, 1, 0);
    check_state("clamp_mo", 0, 0, 0, 28, 2, 2023, 0, 0, 0);

    goto_date(2024, 2, 29, 0, 0, 0);
    step(0, 0, 0, 5, 1, 0);
    check_state("clamp_yr", 0, 0, 0, 28, 2, 2025, 0, 0, 0);

    goto_date(2024, 6, 15, 12, 34, 59);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 0);
    check_state("frozen", 59, 34, 12, 15, 6, 2024, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1);
    check_state("updown", 59, 34, 12, 15, 6, 2024, 0, 0, 0);
    step(0, 0, 0, 7, 1, 0);
    check_state("sel7", 59, 34, 12, 15, 6, 2024, 0, 0, 0);
    step(0, 0, 0, 6, 0, 1);
    check_state("sel6", 59, 34, 12, 15, 6, 2024, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    check_state("ss_wrap", 0, 34, 12, 15, 6, 2024, 0, 0, 0);

    goto_date(2999, 12, 31, 23, 59, 59);
    step(1, 1, 1, 0, 0, 0);
    check_state("rst_cascade", 0, 0, 0, 1, 1, 2000, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    check_state("rst_after", 0, 0, 0, 1, 1, 2000, 0, 0, 0);

    goto_date(2999, 12, 31, 23, 58, 30);
    e = 1;
    for (int i = 0; i < 5000; i++) begin
      r = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 29) == 0) e = ~e;
      t = e ? ($urandom_range(0, 3) != 0) : $urandom_range(0, 1);
      s = 3'($urandom_range(0, 7));
      u = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 3) == 0);
      step(r, t, e, s, u, d);
      check_state("rand", m_ss, m_mm, m_hh, m_dd, m_mo, m_yr, m_min, m_day, m_wrap);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
